spi_tm_master: RTL

- Parametrised successor of the TM1638-style 3-wire serial master.
- Sends one 8-bit command followed by 0..MAX_BYTES data bytes in a single strobe-low transaction.
- Supports both write bursts and read bursts: the master releases DIO after the command and samples data driven by the device.
- Sits between the display/keypad controller logic and the pads (o_SPI_Dio_Out/o_SPI_Dio_Oe feed a tristate at top level).

---
 rtl/spi_tm_master_if.sv | 25 ++
 rtl/spi_tm_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tm_master_if.sv
// Host-side request/response bundle for spi_tm_master.
// The master modport is the requesting controller; the slave modport is the serial engine.
interface spi_tm_master_if #(
  parameter int MAX_BYTES = 4,
  parameter int NB_W      = $clog2(MAX_BYTES + 1)
);
  logic                   i_Data_Ready;
  logic [7:0]             i_Cmd;
  logic                   i_Read;
  logic [NB_W-1:0]        i_Num_Bytes;
  logic [8*MAX_BYTES-1:0] i_Wr_Data;
  logic                   o_Busy;
  logic [8*MAX_BYTES-1:0] o_Rd_Data;
  logic                   o_Rd_Valid;

  modport master (
    output i_Data_Ready, i_Cmd, i_Read, i_Num_Bytes, i_Wr_Data,
    input  o_Busy, o_Rd_Data, o_Rd_Valid
  );

  modport slave (
    input  i_Data_Ready, i_Cmd, i_Read, i_Num_Bytes, i_Wr_Data,
    output o_Busy, o_Rd_Data, o_Rd_Valid
  );
endinterface

// File: rtl/spi_tm_master.sv
// TM1638-style 3-wire serial master: one command byte, then 0..MAX_BYTES write or read bytes
// inside a single strobe-low window. All pad outputs come straight from flops.
module spi_tm_master #(
  parameter int CYCLES       = 1,
  parameter int MAX_BYTES    = 4,
  parameter int TWAIT_CYCLES = 25,
  parameter int PAUSE_CYCLES = 4,
  parameter int NB_W         = $clog2(MAX_BYTES + 1)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  spi_tm_master_if.slave    host,
  output logic              o_SPI_Stb,
  output logic              o_SPI_Clk,
  output logic              o_SPI_Dio_Out,
  output logic              o_SPI_Dio_Oe,
  input  logic              i_SPI_Dio_In
);

  localparam int BW    = $clog2(MAX_BYTES + 2);
  localparam int CMAX0 = (CYCLES > TWAIT_CYCLES) ? CYCLES : TWAIT_CYCLES;
  localparam int CMAX  = (CMAX0 > PAUSE_CYCLES) ? CMAX0 : PAUSE_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int DW    = 8 * MAX_BYTES;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_BIT_LOW  = 3'd2,
    S_BIT_HIGH = 3'd3,
    S_WAIT     = 3'd4,
    S_PAUSE    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   byte_q, byte_d;     // 0 = command byte, k+1 = data byte k
  logic [BW-1:0]   nbytes_q, nbytes_d;
  logic [7:0]      cmd_q, cmd_d;
  logic            read_q, read_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            busy_q, busy_d;
  logic            rd_valid_q, rd_valid_d;
  logic            stb_q, stb_d;
  logic            sclk_q, sclk_d;
  logic            dout_q, dout_d;
  logic            oe_q, oe_d;

  logic [NB_W-1:0] nb_clamped_s;
  logic            rd_bit_s;
  logic [7:0]      byte_sel_s;

  function automatic logic [7:0] pick_byte(input logic [7:0] cmd, input logic [DW-1:0] wr,
                                           input logic [BW-1:0] idx);
    logic [7:0] b;
    b = cmd;
    for (int k = 0; k < MAX_BYTES; k++) begin
      b = (idx == BW'(k + 1)) ? wr[8*k +: 8] : b;
    end
    return b;
  endfunction

  function automatic logic [DW-1:0] put_byte(input logic [DW-1:0] d, input logic [BW-1:0] idx,
                                             input logic [7:0] b);
    logic [DW-1:0] r;
    r = d;
    for (int k = 0; k < MAX_BYTES; k++) begin
      r[8*k +: 8] = (idx == BW'(k + 1)) ? b : r[8*k +: 8];
    end
    return r;
  endfunction

  // Next-state, datapath and pad-output decode
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    nbytes_d   = nbytes_q;
    cmd_d      = cmd_q;
    read_d     = read_q;
    wr_data_d  = wr_data_q;
    shreg_d    = shreg_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    stb_d      = 1'b1;
    sclk_d     = 1'b1;
    dout_d     = 1'b0;
    oe_d       = 1'b0;
    byte_sel_s = 8'h00;

    nb_clamped_s = (host.i_Num_Bytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : host.i_Num_Bytes;
    rd_bit_s     = read_q && (byte_q != '0);

    case (state_q)
      S_IDLE: begin
        if (host.i_Data_Ready) begin
          cmd_d     = host.i_Cmd;
          // a zero-length read behaves exactly like a command-only write
          read_d    = host.i_Read && (nb_clamped_s != '0);
          nbytes_d  = BW'(nb_clamped_s);
          wr_data_d = host.i_Wr_Data;
          state_d   = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        cyc_d   = '0;
        bit_d   = 3'd0;
        byte_d  = '0;
        shreg_d = 8'h00;
        if (read_q) begin
          rd_data_d = '0;
        end else begin
          rd_data_d = rd_data_q;
        end
        state_d = S_BIT_LOW;
      end
      S_BIT_LOW: begin
        if (cyc_q == CW'(CYCLES)) begin
          cyc_d   = '0;
          state_d = S_BIT_HIGH;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_BIT_HIGH: begin
        if ((cyc_q == '0) && rd_bit_s) begin
          shreg_d = {i_SPI_Dio_In, shreg_q[7:1]};
        end else begin
          shreg_d = shreg_q;
        end
        if (cyc_q == CW'(CYCLES)) begin
          cyc_d = '0;
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            state_d = S_BIT_LOW;
          end else begin
            bit_d = 3'd0;
            if (rd_bit_s) begin
              rd_data_d = put_byte(rd_data_q, byte_q, shreg_q);
            end else begin
              rd_data_d = rd_data_q;
            end
            if (byte_q == nbytes_q) begin
              state_d = S_PAUSE;
            end else if ((byte_q == '0) && read_q) begin
              byte_d  = BW'(1);
              state_d = S_WAIT;
            end else begin
              byte_d  = byte_q + BW'(1);
              state_d = S_BIT_LOW;
            end
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (cyc_q == CW'(TWAIT_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = S_BIT_LOW;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_PAUSE: begin
        if (cyc_q == CW'(PAUSE_CYCLES - 1)) begin
          cyc_d      = '0;
          rd_valid_d = read_q;
          state_d    = S_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pads are decoded from the next state so they register alongside it
    byte_sel_s = pick_byte(cmd_q, wr_data_q, byte_d);
    case (state_d)
      S_BIT_LOW, S_BIT_HIGH: begin
        stb_d  = 1'b0;
        sclk_d = (state_d == S_BIT_HIGH);
        if (read_q && (byte_d != '0)) begin
          oe_d   = 1'b0;
          dout_d = 1'b0;
        end else begin
          oe_d   = 1'b1;
          dout_d = byte_sel_s[bit_d];
        end
      end
      S_WAIT: begin
        stb_d  = 1'b0;
        sclk_d = 1'b1;
        oe_d   = 1'b0;
        dout_d = 1'b0;
      end
      default: begin
        stb_d  = 1'b1;
        sclk_d = 1'b1;
        oe_d   = 1'b0;
        dout_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_q      <= 3'd0;
      byte_q     <= '0;
      nbytes_q   <= '0;
      cmd_q      <= 8'h00;
      read_q     <= 1'b0;
      wr_data_q  <= '0;
      shreg_q    <= 8'h00;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      stb_q      <= 1'b1;
      sclk_q     <= 1'b1;
      dout_q     <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      nbytes_q   <= nbytes_d;
      cmd_q      <= cmd_d;
      read_q     <= read_d;
      wr_data_q  <= wr_data_d;
      shreg_q    <= shreg_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      stb_q      <= stb_d;
      sclk_q     <= sclk_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
    end
  end

  assign host.o_Busy     = busy_q;
  assign host.o_Rd_Data  = rd_data_q;
  assign host.o_Rd_Valid = rd_valid_q;
  assign o_SPI_Stb       = stb_q;
  assign o_SPI_Clk       = sclk_q;
  assign o_SPI_Dio_Out   = dout_q;
  assign o_SPI_Dio_Oe    = oe_q;

endmodule
